// File: rtl/laser_cass_player.sv
// Cassette tape player: streams bytes from a buffer as a two-tone cassette waveform.
// Optional build macro CASS_LOOP_EN enables wrap-around playback controlled by LOOP.
module laser_cass_player #(
  parameter int ADDR_W   = 12,
  parameter int SHORT_HP = 110,
  parameter int STEREO   = 0
) (
  input  logic              CLK10MHZ,
  input  logic              RESET,
  input  logic              PLAY,
  input  logic              STOP,
  input  logic [ADDR_W:0]   LENGTH,
  input  logic              LOOP,
  output logic [ADDR_W-1:0] CASS_BUF_A,
  output logic              CASS_BUF_RD,
  input  logic [7:0]        CASS_BUF_Q,
  output logic              EMU_CASS_EN,
  output logic [1:0]        EMU_CASS_DAT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int HP_W = $clog2(2 * SHORT_HP);
  localparam logic [HP_W-1:0] HP_SHORT_M1 = HP_W'(SHORT_HP - 1);
  localparam logic [HP_W-1:0] HP_LONG_M1  = HP_W'(2 * SHORT_HP - 1);
  localparam logic [ADDR_W:0] MAX_LEN     = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_BITS
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic              rd_q;
  logic              rd_dly_q;
  logic              en_q;
  logic              lvl_q;
  logic              done_q;
  logic [7:0]        shift_q;
  logic [7:0]        next_q;
  logic [HP_W-1:0]   hp_cnt_q;
  logic [1:0]        phase_q;
  logic [2:0]        bit_idx_q;
  logic              pf_q;

  logic [ADDR_W:0] len_clamp;
  logic            is_last;
  logic            hp_end;
  logic            half_last;
  logic            wrap;

  assign len_clamp = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;
  assign is_last   = (({1'b0, addr_q}) + (ADDR_W + 1)'(1)) == len_q;
  // A '1' bit uses four short half-periods, a '0' bit two long ones.
  assign hp_end    = hp_cnt_q == (shift_q[7] ? HP_SHORT_M1 : HP_LONG_M1);
  assign half_last = shift_q[7] ? (phase_q == 2'd3) : (phase_q == 2'd1);

`ifdef CASS_LOOP_EN
  assign wrap = LOOP;
`else
  logic unused_loop;
  assign unused_loop = LOOP;
  assign wrap        = 1'b0;
`endif

  always_ff @(posedge CLK10MHZ or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rd_q      <= 1'b0;
      rd_dly_q  <= 1'b0;
      en_q      <= 1'b0;
      lvl_q     <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      next_q    <= '0;
      hp_cnt_q  <= '0;
      phase_q   <= '0;
      bit_idx_q <= '0;
      pf_q      <= 1'b0;
    end else begin
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      rd_dly_q <= rd_q;
      if (rd_dly_q) begin
        next_q <= CASS_BUF_Q;
      end
      if (STOP) begin
        state_q   <= S_IDLE;
        en_q      <= 1'b0;
        lvl_q     <= 1'b0;
        pf_q      <= 1'b0;
        hp_cnt_q  <= '0;
        phase_q   <= '0;
        bit_idx_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (PLAY) begin
              if (len_clamp == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_FETCH;
                rd_q    <= 1'b1;
                addr_q  <= '0;
                len_q   <= len_clamp;
              end
            end
          end
          S_FETCH: state_q <= S_WAIT;
          S_WAIT: begin
            shift_q <= CASS_BUF_Q;
            state_q <= S_LOAD;
          end
          S_LOAD: begin
            state_q   <= S_BITS;
            en_q      <= 1'b1;
            lvl_q     <= 1'b1;
            hp_cnt_q  <= '0;
            phase_q   <= '0;
            bit_idx_q <= '0;
            pf_q      <= 1'b0;
          end
          S_BITS: begin
            if (!hp_end) begin
              hp_cnt_q <= hp_cnt_q + HP_W'(1);
            end else begin
              hp_cnt_q <= '0;
              if (!half_last) begin
                phase_q <= phase_q + 2'd1;
                lvl_q   <= ~lvl_q;
              end else begin
                phase_q <= '0;
                if (bit_idx_q != 3'd7) begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                  shift_q   <= {shift_q[6:0], 1'b0};
                  lvl_q     <= 1'b1;
                  // Entering bit 7: fetch the following byte so it is ready at the boundary.
                  if (bit_idx_q == 3'd6 && (!is_last || wrap)) begin
                    rd_q   <= 1'b1;
                    addr_q <= is_last ? '0 : addr_q + ADDR_W'(1);
                    pf_q   <= 1'b1;
                  end
                end else if (pf_q) begin
                  shift_q   <= next_q;
                  bit_idx_q <= '0;
                  lvl_q     <= 1'b1;
                  pf_q      <= 1'b0;
                end else begin
                  state_q <= S_IDLE;
                  en_q    <= 1'b0;
                  lvl_q   <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign CASS_BUF_A  = addr_q;
  assign CASS_BUF_RD = rd_q;
  assign EMU_CASS_EN = en_q;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = done_q;

  generate
    if (STEREO != 0) begin : g_stereo
      assign EMU_CASS_DAT = {lvl_q, ~lvl_q};
    end else begin : g_mono
      assign EMU_CASS_DAT = {lvl_q, 1'b0};
    end
  endgenerate

endmodule

// File: tb/tb_laser_cass_player.sv
// Scoreboard bench for laser_cass_player: mono and stereo instances share one tape buffer.
module tb_laser_cass_player;
  localparam int ADDR_W = 11;
  localparam int SHP    = 4;
  localparam int BYTE_CYC = 32 * SHP;

  logic              clk = 1'b0;
  logic              rst;
  logic              play;
  logic              stop;
  logic [ADDR_W:0]   length;
  logic              loop_in;
  logic [ADDR_W-1:0] buf_a, buf_a_st;
  logic              buf_rd, buf_rd_st;
  logic [7:0]        buf_q;
  logic              en, en_st;
  logic [1:0]        dat, dat_st;
  logic              busy, busy_st;
  logic              done, done_st;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  bit  exp_lvl[$];
  int  exp_addr[$];
  int  n_chk = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  laser_cass_player #(.ADDR_W(ADDR_W), .SHORT_HP(SHP), .STEREO(0)) u_dut (
    .CLK10MHZ(clk), .RESET(rst), .PLAY(play), .STOP(stop), .LENGTH(length), .LOOP(loop_in),
    .CASS_BUF_A(buf_a), .CASS_BUF_RD(buf_rd), .CASS_BUF_Q(buf_q), .EMU_CASS_EN(en),
    .EMU_CASS_DAT(dat), .BUSY(busy), .DONE(done));

  laser_cass_player #(.ADDR_W(ADDR_W), .SHORT_HP(SHP), .STEREO(1)) u_dut_st (
    .CLK10MHZ(clk), .RESET(rst), .PLAY(play), .STOP(stop), .LENGTH(length), .LOOP(loop_in),
    .CASS_BUF_A(buf_a_st), .CASS_BUF_RD(buf_rd_st), .CASS_BUF_Q(buf_q), .EMU_CASS_EN(en_st),
    .EMU_CASS_DAT(dat_st), .BUSY(busy_st), .DONE(done_st));

  always @(posedge clk) begin
    if (buf_rd) buf_q <= mem[buf_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected read address and per-cycle level sequence for one byte, MSB first.
  task automatic push_byte(input int addr);
    logic [7:0] b;
    b = mem[addr];
    exp_addr.push_back(addr);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) begin
        for (int h = 0; h < 4; h++)
          for (int c = 0; c < SHP; c++) exp_lvl.push_back((h % 2) == 0);
      end else begin
        for (int h = 0; h < 2; h++)
          for (int c = 0; c < 2 * SHP; c++) exp_lvl.push_back(h == 0);
      end
    end
  endtask

  task automatic flush();
    exp_lvl.delete();
    exp_addr.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_rd) begin
        if (exp_addr.size() == 0) check("rd_extra", buf_rd, 0);
        else check("rd_addr", buf_a, exp_addr.pop_front());
      end
      if (en) begin
        if (exp_lvl.size() == 0) begin
          check("en_extra", en, 0);
        end else begin
          bit l;
          l = exp_lvl.pop_front();
          check("dat_mono", dat, {l, 1'b0});
          check("dat_stereo", dat_st, {l, ~l});
        end
      end else begin
        check("dat_idle_mono", dat, 2'b00);
        check("dat_idle_stereo", dat_st, 2'b01);
      end
    end
  end

  task automatic start_play(input int len);
    @(negedge clk); length = (ADDR_W + 1)'(len); play = 1'b1;
    @(negedge clk); play = 1'b0;
    check("rd_t1", buf_rd, 1); check("a_t1", buf_a, 0); check("busy_t1", busy, 1);
    @(negedge clk); check("rd_t2", buf_rd, 0); check("en_t2", en, 0);
    @(negedge clk); check("en_t2b", en, 0);
    @(negedge clk); check("en_t3", en, 1);
  endtask

  task automatic run_to_done(input int exp_n, input int disturb_at);
    int  n;
    bit  got_done;
    n = 1;
    got_done = 0;
    for (int c = 0; c < exp_n + 20; c++) begin
      @(negedge clk);
      play = 1'b0;
      if (done) begin got_done = 1; break; end
      if (en) n++;
      if (n == disturb_at) begin play = 1'b1; length = 1; end
    end
    check("done_seen", got_done, 1);
    check("en_cycles", n, exp_n);
    check("en_at_done", en, 0);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("lvl_left", exp_lvl.size(), 0);
    check("addr_left", exp_addr.size(), 0);
    $display("PLAY done en_cycles=%0d", n);
  endtask

  task automatic run_en_cycles(input int target, output bit saw_done, output bit saw_idle);
    int n;
    n = 1;
    saw_done = 0;
    saw_idle = 0;
    for (int c = 0; c < target * 2 + 20 && n < target; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (!busy) saw_idle = 1;
      if (en) n++;
    end
    check("en_reach", n, target);
  endtask

  initial begin
    bit sd, si;
    rst = 1'b1; play = 1'b0; stop = 1'b0; length = '0; loop_in = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    #3;
    check("rst_rd", buf_rd, 0); check("rst_en", en, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_a", buf_a, 0); check("rst_dat", dat, 0);
    check("rst_dat_st", dat_st, 2'b01);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single byte A5.
    mem[0] = 8'hA5;
    push_byte(0);
    start_play(1);
    run_to_done(BYTE_CYC, -1);

    // Three bytes with a PLAY pulse while busy that must be ignored.
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h00;
    for (int i = 0; i < 3; i++) push_byte(i);
    start_play(3);
    run_to_done(3 * BYTE_CYC, 60);

    // STOP at cycle 50 of byte 0.
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    push_byte(0); push_byte(1);
    start_play(2);
    run_en_cycles(50, sd, si);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_en", en, 0); check("stop_dat", dat, 0); check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    flush();
    sd = 0;
    repeat (200) begin @(negedge clk); if (done || en) sd = 1; end
    check("stop_quiet", sd, 0);
    $display("STOP mid-byte handled");

    // PLAY and STOP together.
    @(negedge clk); play = 1'b1; stop = 1'b1; length = 1;
    @(negedge clk); play = 1'b0; stop = 1'b0;
    check("playstop_busy", busy, 0); check("playstop_rd", buf_rd, 0);
    $display("PLAY+STOP stays idle");

    // Zero length.
    @(negedge clk); play = 1'b1; length = 0;
    @(negedge clk); play = 1'b0;
    check("len0_done", done, 1); check("len0_rd", buf_rd, 0);
    check("len0_en", en, 0); check("len0_busy", busy, 0);
    @(negedge clk); check("len0_done_off", done, 0);
    $display("LENGTH=0 done pulse");

    // Asynchronous reset in the middle of byte 1 of three.
    mem[0] = 8'h55; mem[1] = 8'hAA; mem[2] = 8'h0F;
    for (int i = 0; i < 3; i++) push_byte(i);
    start_play(3);
    run_en_cycles(BYTE_CYC + 70, sd, si);
    check("pre_rst_a", buf_a, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_en", en, 0); check("arst_rd", buf_rd, 0); check("arst_busy", busy, 0);
    check("arst_done", done, 0); check("arst_a", buf_a, 0); check("arst_dat", dat, 0);
    check("arst_dat_st", dat_st, 2'b01);
    flush();
    @(negedge clk); rst = 1'b0;
    sd = 0;
    repeat (30) begin @(negedge clk); if (done || en || busy) sd = 1; end
    check("rst_quiet", sd, 0);
    $display("RESET mid-bit handled");

`ifdef CASS_LOOP_EN
    // Loop over two bytes: addresses 0,1,0,1 and no DONE.
    mem[0] = 8'hA5; mem[1] = 8'h0F;
    loop_in = 1'b1;
    push_byte(0); push_byte(1); push_byte(0); push_byte(1);
    start_play(2);
    run_en_cycles(3 * BYTE_CYC + 50, sd, si);
    check("loop_no_done", sd, 0);
    check("loop_busy", si, 0);
    check("loop_addr_left", exp_addr.size(), 0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; loop_in = 1'b0;
    flush();
    check("loop_stop_busy", busy, 0);
    $display("LOOP sequence 0,1,0,1");
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/laser_cass_player.md
LASER_CASS_PLAYER -- requirements
Module: laser_cass_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, tape-buffer address width (11..14 = 2K..16K).
REQ-002 SHALL have parameter SHORT_HP, default 110, short half-period in CLK10MHZ cycles (range 2..4095).
REQ-003 SHALL have parameter STEREO, default 0, output channel mode (0 = mono, 1 = differential pair).
REQ-004 SHALL have port CLK10MHZ  input  1  sole clock, all state on the rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PLAY  input  1  start request, sampled per cycle.
REQ-007 SHALL have port STOP  input  1  abort request, sampled per cycle.
REQ-008 SHALL have port LENGTH  input  ADDR_W+1  bytes to play, captured on accepted PLAY.
REQ-009 SHALL have port LOOP  input  1  wrap-around request, honoured only with CASS_LOOP_EN.
REQ-010 SHALL have port CASS_BUF_A  output  ADDR_W  buffer read address.
REQ-011 SHALL have port CASS_BUF_RD  output  1  buffer read strobe.
REQ-012 SHALL have port CASS_BUF_Q  input  8  buffer data, valid one cycle after CASS_BUF_RD.
REQ-013 SHALL have port EMU_CASS_EN  output  1  high while the waveform drives the cassette input.
REQ-014 SHALL have port EMU_CASS_DAT  output  2  waveform: {lvl,1'b0} if STEREO=0, {lvl,~lvl} if STEREO=1.
REQ-015 SHALL have port BUSY  output  1  high in any state except IDLE.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse at normal end of tape.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, LOAD, BITS; IDLE->FETCH on PLAY, FETCH->WAIT->LOAD->BITS unconditionally, BITS->IDLE at end of tape.
REQ-018 SHALL, for PLAY sampled at edge t: CASS_BUF_RD=1, CASS_BUF_A=0 in cycle t+1; byte latched at t+2; EMU_CASS_EN=1, first half-period starts at t+3.
REQ-019 SHALL shift each byte MSB first; bit 1 = 4 half-periods of SHORT_HP (high, low, high, low); bit 0 = 2 half-periods of 2*SHORT_HP (high, low); each bit lasts 4*SHORT_HP cycles.
REQ-020 SHALL prefetch the next byte during bit 7 of the current byte, so there is zero gap between consecutive bytes.
REQ-021 SHALL size the half-period counter to hold 2*SHORT_HP-1 without overflow.
REQ-022 SHALL clamp a LENGTH larger than 2^ADDR_W to 2^ADDR_W.
REQ-023 SHALL, at end of the last byte's bit 7: return to IDLE, drop EMU_CASS_EN, drive lvl=0, and pulse DONE in the same cycle.
REQ-024 SHALL, for LENGTH=0: ignore PLAY except for a DONE pulse on the next cycle, with no buffer read and EMU_CASS_EN held 0.
REQ-025 SHALL ignore PLAY while BUSY=1.
REQ-026 SHALL, on STOP in any state: enter IDLE next cycle with EMU_CASS_EN=0, lvl=0, no DONE; STOP wins over a simultaneous PLAY.
REQ-027 SHALL hold EMU_CASS_DAT at 2'b00 (mono) or 2'b01 (stereo) whenever EMU_CASS_EN=0.
REQ-028 SHALL assert CASS_BUF_RD for exactly one cycle per byte fetched.

Reset
REQ-029 SHALL, on RESET, immediately force: state IDLE, CASS_BUF_A=0, CASS_BUF_RD=0, EMU_CASS_EN=0, lvl=0, BUSY=0, DONE=0, counters and shift register 0.
REQ-030 SHALL, on RESET mid-play, abandon the tape without DONE and require a fresh PLAY after release.

Configuration
REQ-031 SHALL use macro CASS_LOOP_EN; when defined and LOOP=1 at the end of tape, address wraps to 0 with no gap, no DONE, and BUSY stays 1 until STOP.
REQ-032 SHALL, when CASS_LOOP_EN is undefined, omit the loop logic entirely and ignore LOOP.

Verification
REQ-033 SHALL cover: SHORT_HP=4, LENGTH=1, buffer[0]=8'hA5, PLAY -> RD at t+1, EN at t+3, 128 cycles of waveform bits 1,0,1,0,0,1,0,1, then DONE pulse and EN=0.
REQ-034 SHALL cover: LENGTH=3, bytes 00/FF/00 -> exactly 3 RD pulses, 384 contiguous waveform cycles, no level glitch at byte boundaries.
REQ-035 SHALL cover: STOP at cycle 50 of byte 0 -> EN=0 and DAT=00 next cycle, no DONE; PLAY+STOP in the same cycle -> stays IDLE.
REQ-036 SHALL cover: LENGTH=0 with PLAY -> DONE on the next cycle, no RD, EN=0; PLAY while BUSY -> no effect on address or timing.
REQ-037 SHALL cover: RESET asserted mid-bit -> all outputs at reset values asynchronously, before the next clock edge.
REQ-038 SHALL cover: CASS_LOOP_EN defined, LOOP=1, LENGTH=2 -> address sequence 0,1,0,1 with no DONE; STEREO=1 -> DAT[0] always the inverse of DAT[1] while EN=1.
